// File: rtl/ecc_pkg.sv
// Shared constants and helpers for the 128/8 Hamming codec.
package ecc_pkg;

  localparam int unsigned DATA_W       = 128;
  localparam int unsigned CODE_W       = 8;
  localparam logic [7:0]  CODE_POS_MAX = 8'd136;

  // Position of data bit idx: the (idx+1)-th non-power-of-two starting at 1.
  // Every power of two at or below the running position pushes it up by one.
  function automatic logic [7:0] data_pos(input int unsigned idx);
    int unsigned p;
    p = idx + 1;
    for (int unsigned k = 0; k < CODE_W; k++) begin
      if ((32'd1 << k) <= p) p++;
    end
    return p[7:0];
  endfunction

  // Check bits of a 128-bit word: XOR of the positions of all set data bits.
  function automatic logic [CODE_W-1:0] calc_code(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (data[i]) c ^= data_pos(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/ecc_syndrome_dec.sv
// Syndrome decoder: turns an 8-bit syndrome into a data flip mask and flags.
module ecc_syndrome_dec
  import ecc_pkg::*;
(
  input  logic [7:0]        syndrome,
  output logic [DATA_W-1:0] flip_mask,
  output logic              err_corr,
  output logic              err_uncorr
);

  // One-hot mask on the data bit whose position equals the syndrome; check-bit
  // positions match no data bit and so leave the mask empty.
  always_comb begin
    flip_mask = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      flip_mask[i] = (syndrome == data_pos(i));
    end
    err_corr   = (syndrome != 8'd0) && (syndrome <= CODE_POS_MAX);
    err_uncorr = (syndrome > CODE_POS_MAX);
  end

endmodule

// File: rtl/ecc_codec.sv
// 128-bit SEC Hamming codec: registered encoder and decoder sharing clk/rst.
// Build option: define ECC_DEC_PIPE_EN for a two-stage decoder (latency 2).
module ecc_codec
  import ecc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       data_0,
  input  logic [15:0]       data_1,
  input  logic [15:0]       data_2,
  input  logic [15:0]       data_3,
  input  logic [15:0]       data_4,
  input  logic [15:0]       data_5,
  input  logic [15:0]       data_6,
  input  logic [15:0]       data_7,
  output logic [CODE_W-1:0] code,
  input  logic [DATA_W-1:0] dec_data,
  input  logic [CODE_W-1:0] dec_code,
  output logic [DATA_W-1:0] cr_data,
  output logic              err_corr,
  output logic              err_uncorr
);

  logic [DATA_W-1:0] enc_word;
  logic [CODE_W-1:0] syn_now;
  logic [CODE_W-1:0] stage_syn;
  logic [DATA_W-1:0] stage_data;
  logic [DATA_W-1:0] flip_mask;
  logic              corr_c;
  logic              uncorr_c;

  assign enc_word = {data_7, data_6, data_5, data_4, data_3, data_2, data_1, data_0};
  assign syn_now  = calc_code(dec_data) ^ dec_code;

  // Encoder: register check bits of the current lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) code <= '0;
    else     code <= calc_code(enc_word);
  end

`ifdef ECC_DEC_PIPE_EN
  logic [CODE_W-1:0] syn_q;
  logic [DATA_W-1:0] data_q;

  // Decoder stage 1: hold the syndrome alongside the data it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syn_q  <= '0;
      data_q <= '0;
    end else begin
      syn_q  <= syn_now;
      data_q <= dec_data;
    end
  end

  assign stage_syn  = syn_q;
  assign stage_data = data_q;
`else
  assign stage_syn  = syn_now;
  assign stage_data = dec_data;
`endif

  ecc_syndrome_dec u_syndrome_dec (
    .syndrome   (stage_syn),
    .flip_mask  (flip_mask),
    .err_corr   (corr_c),
    .err_uncorr (uncorr_c)
  );

  // Decoder output stage: apply the correction and register the flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_data    <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
    end else begin
      cr_data    <= stage_data ^ flip_mask;
      err_corr   <= corr_c;
      err_uncorr <= uncorr_c;
    end
  end

endmodule

// File: tb/tb_ecc_codec.sv
// Directed and random self-checking bench for ecc_codec.
module tb_ecc_codec;

`ifdef ECC_DEC_PIPE_EN
  localparam int unsigned DEC_LAT = 2;
`else
  localparam int unsigned DEC_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  data_0, data_1, data_2, data_3, data_4, data_5, data_6, data_7;
  logic [7:0]   code;
  logic [127:0] dec_data;
  logic [7:0]   dec_code;
  logic [127:0] cr_data;
  logic         err_corr;
  logic         err_uncorr;

  int unsigned tests = 0;
  int unsigned fails = 0;

  ecc_codec dut (
    .clk        (clk),
    .rst        (rst),
    .data_0     (data_0),
    .data_1     (data_1),
    .data_2     (data_2),
    .data_3     (data_3),
    .data_4     (data_4),
    .data_5     (data_5),
    .data_6     (data_6),
    .data_7     (data_7),
    .code       (code),
    .dec_data   (dec_data),
    .dec_code   (dec_code),
    .cr_data    (cr_data),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr)
  );

  always #5 clk = ~clk;

  // Reference check bits: walk positions 1..136, skipping powers of two, and
  // XOR in the position of every set data bit.
  function automatic logic [7:0] ref_code(input logic [127:0] d);
    logic [7:0]  c;
    int unsigned idx;
    c   = 8'h00;
    idx = 0;
    for (int unsigned p = 1; p <= 136; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[idx]) c ^= p[7:0];
        idx++;
      end
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_lanes(input logic [127:0] w);
    data_0 = w[15:0];    data_1 = w[31:16];   data_2 = w[47:32];   data_3 = w[63:48];
    data_4 = w[79:64];   data_5 = w[95:80];   data_6 = w[111:96];  data_7 = w[127:112];
  endtask

  logic [127:0] word;
  logic [127:0] one;
  int unsigned  c;

  initial begin
    // Reset held with nonzero inputs
    set_lanes(128'h0000_0000_0000_0000_0000_0000_0000_0001);
    dec_data = 128'h0;
    dec_code = 8'h03;
    #1;
    check("rst_code",   {120'h0, code}, 128'h0);
    check("rst_cr",     cr_data, 128'h0);
    check("rst_corr",   {127'h0, err_corr}, 128'h0);
    check("rst_uncorr", {127'h0, err_uncorr}, 128'h0);
    tick(2);
    check("rst_hold_code", {120'h0, code}, 128'h0);
    check("rst_hold_cr",   cr_data, 128'h0);

    // Release reset; outputs follow after their latencies
    rst = 1'b0;
    tick(1);
    check("post_rst_code", {120'h0, code}, 128'h03);
`ifdef ECC_DEC_PIPE_EN
    check("post_rst_cr_early", cr_data, 128'h0);
`endif
    tick(DEC_LAT - 1);
    check("post_rst_cr",   cr_data, 128'h1);
    check("post_rst_corr", {127'h0, err_corr}, 128'h1);

    // Mid-stream reset clears everything at once
    rst = 1'b1;
    #1;
    check("mid_rst_code", {120'h0, code}, 128'h0);
    check("mid_rst_cr",   cr_data, 128'h0);
    check("mid_rst_corr", {127'h0, err_corr}, 128'h0);
    tick(1);
    rst = 1'b0;

    // Encoder directed vectors
    set_lanes(128'h0);
    tick(1);
    check("enc_zero", {120'h0, code}, 128'h00);
    set_lanes(128'h1);
    tick(1);
    check("enc_bit0", {120'h0, code}, 128'h03);
    set_lanes(128'h3);
    tick(1);
    check("enc_bit01", {120'h0, code}, 128'h06);
    data_0 = 16'h0000;
    data_7 = 16'h8000;
    tick(1);
    check("enc_bit127", {120'h0, code}, 128'h88);

    // Decoder: data-bit error at position 3 (bit0)
    dec_data = 128'h0;
    dec_code = 8'h03;
    tick(DEC_LAT);
    check("dec_bit0_cr",     cr_data, 128'h1);
    check("dec_bit0_corr",   {127'h0, err_corr}, 128'h1);
    check("dec_bit0_uncorr", {127'h0, err_uncorr}, 128'h0);

    // Decoder: check-bit error
    dec_code = 8'h01;
    tick(DEC_LAT);
    check("dec_chk_cr",     cr_data, 128'h0);
    check("dec_chk_corr",   {127'h0, err_corr}, 128'h1);
    check("dec_chk_uncorr", {127'h0, err_uncorr}, 128'h0);

    // Decoder: syndrome beyond the codeword
    dec_code = 8'hFF;
    tick(DEC_LAT);
    check("dec_unc_cr",     cr_data, 128'h0);
    check("dec_unc_corr",   {127'h0, err_corr}, 128'h0);
    check("dec_unc_uncorr", {127'h0, err_uncorr}, 128'h1);

    // Decoder: clean word
    dec_data = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    dec_code = 8'h88;
    tick(DEC_LAT);
    check("dec_clean_cr",   cr_data, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    check("dec_clean_corr", {127'h0, err_corr}, 128'h0);

    // Random encode, flip one bit, decode
    for (int unsigned it = 0; it < 1000; it++) begin
      word = {$urandom, $urandom, $urandom, $urandom};
      c    = $urandom_range(127, 0);
      set_lanes(word);
      tick(1);
      check("rnd_code", {120'h0, code}, {120'h0, ref_code(word)});
      one      = 128'h1;
      dec_data = word ^ (one << c);
      dec_code = code;
      tick(DEC_LAT);
      check("rnd_cr",     cr_data, word);
      check("rnd_corr",   {127'h0, err_corr}, 128'h1);
      check("rnd_uncorr", {127'h0, err_uncorr}, 128'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecc_codec.md
# ecc_codec

128-bit single-error-correcting Hamming codec with 8 check bits. It holds a registered encoder, which produces check bits from eight 16-bit lanes, and a registered decoder, which recomputes the syndrome and corrects one flipped data bit. It sits between the datapath and storage: the encoder runs on the write side and the decoder on the read side. The two paths are independent and share only the clock and reset.

## Interface
Parameters: none. Widths are fixed: 128 data bits, 8 check bits.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- data_0 … data_7  in  16 each  encoder input lanes; data_k maps to bits [16k+15:16k] of the 128-bit word.
- code  out  8  encoder check bits, registered.
- dec_data  in  128  decoder data, possibly corrupted.
- dec_code  in  8  decoder check bits, as stored.
- cr_data  out  128  corrected data, registered.
- err_corr  out  1  a single-bit error was detected and handled (data bit or check bit).
- err_uncorr  out  1  the syndrome points outside the codeword.

## Operation
- Position map: data bit i takes the (i+1)-th integer in 1..136 that is not a power of two.
  - Examples: bit0→3, bit1→5, bit2→6, bit3→7, bit4→9, bit127→136.
  - Check bit k sits at position 2^k, for k = 0..7.
- Encoder: code[k] = XOR of all data bits whose position has bit k set.
- Decoder syndrome: s = recomputed check bits of dec_data XOR dec_code.
  - s == 0: cr_data = dec_data; both flags 0.
  - s equals a data position: cr_data = dec_data with that bit inverted; err_corr = 1.
  - s is a power of two (check-bit error): cr_data = dec_data; err_corr = 1.
  - s in 137..255: cr_data = dec_data unchanged; err_uncorr = 1.
- There is no double-error detection. A double error may be miscorrected, and that is accepted behaviour.
- Both paths are purely feed-forward. There is no handshake and no valid signal; every cycle is a new sample.

## Timing
- Encoder: code reflects the data lanes sampled at the previous rising edge (latency 1).
- Decoder: cr_data, err_corr and err_uncorr reflect dec_data and dec_code sampled at the previous edge (latency 1, or 2 when ECC_DEC_PIPE_EN is defined).
- Reset: code, cr_data, err_corr and err_uncorr clear to 0 immediately, and any pipeline register clears too. The first valid output appears one latency period after the first edge with rst low.
- Reset mid-stream: in-flight samples are discarded with no partial output.
- Inputs that change every cycle are supported at full throughput.

## Configuration
- ECC_DEC_PIPE_EN defined:
  - The decoder registers the syndrome together with a delayed copy of dec_data.
  - Correction and the flags are registered in a second stage.
  - Decoder latency is 2 cycles; the encoder is unchanged.
- Undefined: syndrome, correction and flags are computed combinationally in one stage; decoder latency is 1.

## Structure
- Package ecc_pkg holds:
  - constants DATA_W = 128, CODE_W = 8, CODE_POS_MAX = 136;
  - a function mapping a data index to its position;
  - a function computing check bits from 128 data bits, shared by both paths.
- Sub-module ecc_syndrome_dec: maps an 8-bit syndrome to a 128-bit flip mask plus the err_corr and err_uncorr flags.
- The encoder and decoder registers live in ecc_codec.

## Test plan
- Reset with inputs nonzero → code = 8'h00, cr_data = 0, flags = 0 while rst = 1. Deassert → outputs follow after the configured latency.
- Encoder lanes all 0 → code = 8'h00. data_0 = 16'h0001 → code = 8'h03. data_7 = 16'h8000 (bit127) → code = 8'h88.
- Decoder dec_data = 128'h0, dec_code = 8'h03 → cr_data = 128'h1, err_corr = 1.
- Check-bit error: dec_data = 128'h0, dec_code = 8'h01 → cr_data = 0, err_corr = 1, err_uncorr = 0.
- Uncorrectable: dec_data = 0, dec_code = 8'hFF → cr_data = 0, err_uncorr = 1.
- Random loop of 1000 iterations:
  - Encode a random word, then feed the decoder that word with one random bit c (0..127) inverted, plus the encoder's code.
  - Required: cr_data equals the original word and err_corr = 1.
  - Run with and without ECC_DEC_PIPE_EN.
